wfunc_cfg_loader: RTL and testbench
===================================

// Module: wfunc_cfg_loader
// PURPOSE
// - APB master that (re)configures window_func: brings its FSM to IDLE, streams FFT_SIZE window
//   coefficients from an AXI-Stream source into window RAM, issues CHANGE STATE to arm it (IDLE->WAIT),
//   then reads back status to confirm WAIT.
// - Sits between a coefficient source (DMA/ROM) and the window_func APB slave port.
// PARAMETERS
// - FFT_SIZE  8192                      window length, power of 2; must match window_func
// - APB_AW    $clog2(FFT_SIZE-1)+2+1    APB address width; do not change
// - POLL_MAX  1024                      max status reads while window_func is BUSY before forced soft reset
// PORTS
// - clk          in   1       clock
// - rst_n        in   1       asynchronous active-low reset
// - cfg_start    in   1       pulse: begin reconfiguration; ignored while busy=1
// - coef_tvalid  in   1       coefficient stream valid
// - coef_tready  out  1       coefficient stream ready
// - coef_tdata   in   32      [31:16] Im, [15:0] Re, index order 0..FFT_SIZE-1
// - coef_tlast   in   1       must mark beat FFT_SIZE-1
// - psel         out  1       APB select
// - penable      out  1       APB enable
// - pwrite       out  1       APB write
// - paddr        out  APB_AW  APB byte address
// - pwdata       out  32      APB write data
// - prdata       in   32      APB read data
// - busy         out  1       sequence in progress
// - done         out  1       1-cycle pulse at end of sequence (success or error)
// - err          out  2       valid with done, held until next cfg_start: 00 ok, 01 length, 10 arm fail
// - flushed      out  1       valid with done: soft reset was used to leave BUSY
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; counters 0.
// - APB: no wait states. Each transfer = setup (psel=1,penable=0) + access (psel=1,penable=1).
//   Reads: prdata sampled at end of access cycle. psel=0 between transfers, except in LOAD (see below).
//   paddr/pwrite/pwdata are stable across both phases of a transfer.
// - Addresses: window[i] = i*4; CTRL = FFT_SIZE*4; STAT = (FFT_SIZE+1)*4; state = STAT[9:8].
// - FSM:
//   IDLE:    cfg_start -> clear err/flushed, busy=1, poll_cnt=0 -> RD_STAT.
//   RD_STAT: read STAT. 00 -> LOAD; 01 -> WR_CS (write CTRL=0x100), then RD_STAT;
//            10 -> poll_cnt+1, RD_STAT; poll_cnt==POLL_MAX -> WR_RST (write CTRL=0x1), flushed=1, then RD_STAT;
//            11 -> treat as 10.
//   LOAD:    idx 0..FFT_SIZE-1. coef_tready=1 only in the cycle before a setup phase can start.
//            Handshake at cycle t -> setup t+1, access t+2; next handshake allowed at t+2.
//            Peak rate: 1 beat / 2 cycles; psel stays high back-to-back.
//            No coef_tvalid -> psel=0 and wait; no timeout.
//            coef_tlast on idx<FFT_SIZE-1 -> write that beat, err=01 -> DONE (no arm).
//            idx==FFT_SIZE-1 without tlast -> write it, err=01 -> DONE.
//            Otherwise -> ARM.
//   ARM:     write CTRL=0x100 -> VERIFY.
//   VERIFY:  read STAT. 01 or 10 -> err=00 (10 = packet already started); else err=10 -> DONE.
//   DONE:    done=1 for one cycle, busy=0 -> IDLE.
// - coef_tready is never asserted outside LOAD. Beats offered outside LOAD are not consumed.
// - idx width $clog2(FFT_SIZE). Increments after each write access; no wrap within a sequence.
// - cfg_start while busy: ignored. Simultaneous cfg_start and done: start ignored; needs a new pulse.
// - Async reset mid-transfer: psel/penable drop immediately. The partial window is lost.
//   window_func state is not restored; the next cfg_start recovers it via RD_STAT.
// TESTING (FFT_SIZE=16, POLL_MAX=4, window_func model attached)
// - Target IDLE, start, 16 beats with tlast on 15 -> 16 writes to 0x00..0x3C, CTRL 0x100 write.
//   Then STAT reads 0x100, done with err=00, flushed=0; RAM readback matches data.
// - Target in WAIT at start -> CTRL 0x100 write, STAT reread 0x000, then load; success.
// - Target BUSY forever (no tlast on data) -> 4 polls, then CTRL 0x1 write, then load.
//   done with err=00, flushed=1.
// - tlast on beat 7 -> 8 writes only, no CTRL write, done with err=01.
// - Source stalls tvalid low 5 cycles mid-load -> psel=0 during stall.
//   No duplicate or skipped address; back-to-back rate otherwise 2 cycles/beat.
// - rst_n low during LOAD beat 5 -> psel, busy, coef_tready = 0 at once.
//   Fresh cfg_start completes normally.

Source files
------------

// File: rtl/wfunc_cfg_loader.sv
// APB master that reconfigures window_func: brings it to IDLE, streams the window
// coefficients into its RAM, arms it (IDLE->WAIT) and confirms the new state.
module wfunc_cfg_loader #(
  parameter int FFT_SIZE = 8192,
  parameter int APB_AW   = $clog2(FFT_SIZE-1)+2+1,
  parameter int POLL_MAX = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              coef_tvalid,
  output logic              coef_tready,
  input  logic [31:0]       coef_tdata,
  input  logic              coef_tlast,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              flushed
);

  localparam int IDX_W  = $clog2(FFT_SIZE);
  localparam int PC_W   = $clog2(POLL_MAX+1);
  localparam int CTRL_I = FFT_SIZE*4;
  localparam int STAT_I = (FFT_SIZE+1)*4;
  localparam int LAST_I = FFT_SIZE-1;

  localparam logic [APB_AW-1:0] CTRL_ADDR = CTRL_I[APB_AW-1:0];
  localparam logic [APB_AW-1:0] STAT_ADDR = STAT_I[APB_AW-1:0];
  localparam logic [IDX_W-1:0]  IDX_LAST  = LAST_I[IDX_W-1:0];
  localparam logic [PC_W-1:0]   POLL_LIM  = POLL_MAX[PC_W-1:0];
  localparam logic [IDX_W-1:0]  IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]   PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_RD_STAT, S_WR_CS, S_WR_RST, S_LOAD, S_ARM, S_VERIFY, S_DONE
  } state_t;

  // PH_GAP keeps psel low for one cycle between register transfers.
  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

  state_t            state, state_n;
  phase_t            phase, phase_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [PC_W-1:0]   poll_cnt, poll_n, poll_inc;
  logic [31:0]       coef_q, coef_n;
  logic              last_q, last_n;
  logic [1:0]        err_n;
  logic              flushed_n;
  logic [1:0]        stat;
  logic              beat_final;
  logic              is_wr;
  logic              hs;
  logic              unused_prdata;

  assign stat          = prdata[9:8];
  assign unused_prdata = ^{prdata[31:10], prdata[7:0]};
  assign poll_inc      = poll_cnt + PC_ONE;
  assign beat_final    = last_q || (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      phase    <= PH_GAP;
      idx      <= '0;
      poll_cnt <= '0;
      coef_q   <= '0;
      last_q   <= 1'b0;
      err      <= 2'b00;
      flushed  <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      idx      <= idx_n;
      poll_cnt <= poll_n;
      coef_q   <= coef_n;
      last_q   <= last_n;
      err      <= err_n;
      flushed  <= flushed_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    idx_n       = idx;
    poll_n      = poll_cnt;
    coef_n      = coef_q;
    last_n      = last_q;
    err_n       = err;
    flushed_n   = flushed;
    psel        = 1'b0;
    penable     = 1'b0;
    pwrite      = 1'b0;
    paddr       = '0;
    pwdata      = '0;
    coef_tready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    hs          = 1'b0;
    is_wr       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (cfg_start) begin
          state_n   = S_RD_STAT;
          phase_n   = PH_GAP;
          err_n     = 2'b00;
          flushed_n = 1'b0;
          poll_n    = '0;
          idx_n     = '0;
          last_n    = 1'b0;
        end
      end

      // A beat is accepted while no transfer is pending or during the access of a
      // non-final beat, so psel stays high when the source keeps up.
      S_LOAD: begin
        busy               = 1'b1;
        psel               = (phase != PH_GAP);
        penable            = (phase == PH_ACCESS);
        pwrite             = 1'b1;
        paddr[IDX_W+1:0]   = {idx, 2'b00};
        pwdata             = coef_q;
        coef_tready        = (phase == PH_GAP) || ((phase == PH_ACCESS) && !beat_final);
        hs                 = coef_tready && coef_tvalid;
        if (hs) begin
          coef_n = coef_tdata;
          last_n = coef_tlast;
        end
        unique case (phase)
          PH_SETUP: phase_n = PH_ACCESS;
          PH_ACCESS: begin
            if (beat_final) begin
              phase_n = PH_GAP;
              if (last_q && (idx == IDX_LAST)) begin
                state_n = S_ARM;
              end else begin
                err_n   = 2'b01;
                state_n = S_DONE;
              end
            end else begin
              idx_n   = idx + IDX_ONE;
              phase_n = hs ? PH_SETUP : PH_GAP;
            end
          end
          default: phase_n = hs ? PH_SETUP : PH_GAP;
        endcase
      end

      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end

      default: begin
        busy    = 1'b1;
        is_wr   = (state == S_WR_CS) || (state == S_WR_RST) || (state == S_ARM);
        psel    = (phase != PH_GAP);
        penable = (phase == PH_ACCESS);
        pwrite  = is_wr;
        paddr   = is_wr ? CTRL_ADDR : STAT_ADDR;
        if (state == S_WR_RST) begin
          pwdata = 32'h0000_0001;
        end else if (is_wr) begin
          pwdata = 32'h0000_0100;
        end
        unique case (phase)
          PH_GAP:   phase_n = PH_SETUP;
          PH_SETUP: phase_n = PH_ACCESS;
          default: begin
            phase_n = PH_GAP;
            unique case (state)
              S_RD_STAT: begin
                unique case (stat)
                  2'b00: state_n = S_LOAD;
                  2'b01: state_n = S_WR_CS;
                  default: begin
                    // BUSY or undefined: poll until the limit, then force a soft reset.
                    if (poll_inc == POLL_LIM) begin
                      state_n   = S_WR_RST;
                      flushed_n = 1'b1;
                      poll_n    = '0;
                    end else begin
                      poll_n = poll_inc;
                    end
                  end
                endcase
              end
              S_ARM: state_n = S_VERIFY;
              S_VERIFY: begin
                err_n   = ((stat == 2'b01) || (stat == 2'b10)) ? 2'b00 : 2'b10;
                state_n = S_DONE;
              end
              default: state_n = S_RD_STAT;
            endcase
          end
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_wfunc_cfg_loader.sv
// Self-checking bench for wfunc_cfg_loader with a small window_func APB slave model
// and a write scoreboard (FFT_SIZE=16, POLL_MAX=4).
module tb_wfunc_cfg_loader;

  localparam int FFT = 16;
  localparam int PM  = 4;
  localparam int AW  = 7;
  localparam logic [AW-1:0] CTRL_A = 7'h40;
  localparam logic [AW-1:0] STAT_A = 7'h44;

  logic          clk;
  logic          rst_n;
  logic          cfg_start;
  logic          coef_tvalid;
  logic          coef_tready;
  logic [31:0]   coef_tdata;
  logic          coef_tlast;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic          flushed;

  wfunc_cfg_loader #(.FFT_SIZE(FFT), .POLL_MAX(PM)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .coef_tvalid(coef_tvalid), .coef_tready(coef_tready),
    .coef_tdata(coef_tdata), .coef_tlast(coef_tlast),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .busy(busy), .done(done),
    .err(err), .flushed(flushed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // window_func model: mode 0 toggles IDLE<->WAIT on CHANGE STATE, mode 1 ignores it,
  // mode 2 jumps IDLE->BUSY (packet already started). BUSY only leaves on soft reset.
  logic [1:0]  wf_state;
  logic [1:0]  wf_init;
  int          wf_mode;
  logic        wf_load;
  logic [31:0] wf_ram [FFT];

  always @(posedge clk) begin
    if (wf_load) begin
      wf_state <= wf_init;
    end else if (psel && penable && pwrite) begin
      if (paddr == CTRL_A) begin
        if (pwdata == 32'h1) begin
          wf_state <= 2'b00;
        end else if (pwdata == 32'h100) begin
          if (wf_mode == 0 && wf_state == 2'b00) wf_state <= 2'b01;
          else if (wf_mode == 0 && wf_state == 2'b01) wf_state <= 2'b00;
          else if (wf_mode == 2 && wf_state == 2'b00) wf_state <= 2'b10;
        end
      end else if (paddr < CTRL_A) begin
        wf_ram[paddr[5:2]] <= pwdata;
      end
    end
  end

  always_comb begin
    prdata = 32'd0;
    if (paddr == STAT_A) prdata = {22'd0, wf_state, 8'd0};
    else if (paddr < CTRL_A) prdata = wf_ram[paddr[5:2]];
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [1:0] init;
    int         mode;
    int         nbeats;
    int         last_at;
    logic [1:0] exp_err;
    logic       exp_flushed;
    int         exp_reads;
  } vec_t;

  wr_t  exp_q[$];
  int   load_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   stat_reads = 0;
  logic [AW-1:0] setup_addr;
  logic [31:0]   setup_data;
  logic          setup_wr;
  logic          setup_valid = 1'b0;
  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got timeout/unexpected event, expected normal completion", name);
  endtask

  function automatic logic [31:0] beatData(input int row, input int i);
    return {16'(row * 16'h1111 + i), 16'(16'hA000 ^ (i * 7))};
  endfunction

  // Bus monitor: protocol stability plus scoreboard pop for every write access.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (psel && !penable) begin
      setup_addr  = paddr;
      setup_data  = pwdata;
      setup_wr    = pwrite;
      setup_valid = 1'b1;
    end else if (psel && penable) begin
      if (setup_valid)
        checkOutput("apb_stable", {paddr, pwdata, pwrite}, {setup_addr, setup_data, setup_wr});
      setup_valid = 1'b0;
      if (pwrite) begin
        if (exp_q.size() == 0) begin
          failNow("unexpected_write");
        end else begin
          e = exp_q.pop_front();
          checkOutput("apb_write", {25'd0, paddr, pwdata}, {25'd0, e.addr, e.data});
        end
        if (paddr < CTRL_A) load_cyc.push_back(cyc);
      end else if (paddr == STAT_A) begin
        stat_reads++;
      end
    end
  end

  task automatic pushWr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic setTarget(input logic [1:0] init, input int mode);
    wf_init = init;
    wf_mode = mode;
    wf_load = 1'b1;
    @(negedge clk);
    wf_load = 1'b0;
    stat_reads = 0;
    load_cyc.delete();
  endtask

  task automatic pulseStart();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  // Offers one beat, waits (bounded) for the handshake and queues the expected write.
  task automatic sendBeat(input int i, input logic [31:0] d, input logic last);
    int n = 0;
    coef_tvalid = 1'b1;
    coef_tdata  = d;
    coef_tlast  = last;
    while (!coef_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!coef_tready) begin
      failNow("tready_timeout");
    end else begin
      pushWr(7'(i * 4), d);
      @(negedge clk);
    end
    coef_tvalid = 1'b0;
    coef_tlast  = 1'b0;
  endtask

  task automatic waitDone(output logic seen);
    int n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    seen = done;
    if (!done) failNow("done_timeout");
  endtask

  task automatic applyStimulus(input int row, input vec_t v);
    logic seen;
    int   bad = 0;
    setTarget(v.init, v.mode);
    if (v.init == 2'b01) pushWr(CTRL_A, 32'h100);
    else if (v.init[1]) pushWr(CTRL_A, 32'h1);
    pulseStart();
    for (int i = 0; i < v.nbeats; i++)
      sendBeat(i, beatData(row, i), (i == v.last_at));
    if (v.nbeats == FFT && v.last_at == FFT - 1) pushWr(CTRL_A, 32'h100);
    waitDone(seen);
    checkOutput($sformatf("v%0d_err", row), {62'd0, err}, {62'd0, v.exp_err});
    checkOutput($sformatf("v%0d_flushed", row), {63'd0, flushed}, {63'd0, v.exp_flushed});
    checkOutput($sformatf("v%0d_busy_at_done", row), {63'd0, busy}, 64'd0);
    checkOutput($sformatf("v%0d_stat_reads", row), 64'(stat_reads), 64'(v.exp_reads));
    checkOutput($sformatf("v%0d_queue_empty", row), 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < v.nbeats; i++)
      if (wf_ram[i] !== beatData(row, i)) bad++;
    checkOutput($sformatf("v%0d_ram_readback", row), 64'(bad), 64'd0);
    // cfg_start coinciding with done must be dropped
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    checkOutput($sformatf("v%0d_done_pulse", row), {62'd0, done, busy}, 64'd0);
    checkOutput($sformatf("v%0d_err_held", row), {62'd0, err}, {62'd0, v.exp_err});
    repeat (2) @(negedge clk);
  endtask

  // Source stalls for 5 cycles after beat 4; a stray cfg_start arrives mid-load.
  task automatic runStall();
    logic seen;
    int   psel_hi = 0;
    int   bad = 0;
    setTarget(2'b00, 0);
    pulseStart();
    for (int i = 0; i < 5; i++) sendBeat(i, beatData(9, i), 1'b0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (psel) psel_hi++;
      cfg_start = (k == 0);
    end
    cfg_start = 1'b0;
    checkOutput("stall_psel_low", 64'(psel_hi), 64'd0);
    for (int i = 5; i < FFT; i++) sendBeat(i, beatData(9, i), (i == FFT - 1));
    pushWr(CTRL_A, 32'h100);
    waitDone(seen);
    checkOutput("stall_err", {62'd0, err}, 64'd0);
    checkOutput("stall_queue_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("stall_write_count", 64'(load_cyc.size()), 64'(FFT));
    if (load_cyc.size() == FFT) begin
      for (int i = 1; i < FFT; i++)
        if (i != 5 && load_cyc[i] - load_cyc[i-1] != 2) bad++;
      checkOutput("b2b_rate", 64'(bad), 64'd0);
      checkOutput("stall_gap", 64'(load_cyc[5] - load_cyc[4]), 64'd6);
    end
    repeat (2) @(negedge clk);
  endtask

  // Async reset during the setup phase of beat 5, then a fresh sequence.
  task automatic runResetMidLoad();
    int n = 0;
    setTarget(2'b00, 0);
    pulseStart();
    for (int i = 0; i < 5; i++) sendBeat(i, beatData(11, i), 1'b0);
    coef_tvalid = 1'b1;
    coef_tdata  = beatData(11, 5);
    while (!coef_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checkOutput("beat5_setup_seen", {62'd0, psel, penable}, 64'd2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_psel", {62'd0, psel, penable}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_tready", {63'd0, coef_tready}, 64'd0);
    coef_tvalid = 1'b0;
    checkOutput("rst_partial_writes", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    //          init   mode beats last  err    fl    reads
    vecs[0] = '{2'b00, 0,   16,   15,   2'b00, 1'b0, 2};
    vecs[1] = '{2'b01, 0,   16,   15,   2'b00, 1'b0, 3};
    vecs[2] = '{2'b10, 0,   16,   15,   2'b00, 1'b1, 6};
    vecs[3] = '{2'b00, 0,   8,    7,    2'b01, 1'b0, 1};
    vecs[4] = '{2'b00, 0,   16,   -1,   2'b01, 1'b0, 1};
    vecs[5] = '{2'b00, 1,   16,   15,   2'b10, 1'b0, 2};
    vecs[6] = '{2'b00, 2,   16,   15,   2'b00, 1'b0, 2};

    rst_n       = 1'b0;
    cfg_start   = 1'b0;
    coef_tvalid = 1'b0;
    coef_tdata  = 32'd0;
    coef_tlast  = 1'b0;
    wf_load     = 1'b0;
    wf_init     = 2'b00;
    wf_mode     = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {16'd0, psel, penable, pwrite, paddr, pwdata, coef_tready, busy, done, err, flushed},
                64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      $display("[TB] vector %0d", r);
      applyStimulus(r, vecs[r]);
    end

    $display("[TB] stall sequence");
    runStall();

    $display("[TB] reset during load");
    runResetMidLoad();
    applyStimulus(12, vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
